// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: front-end stage ahead of the control unit.
// Owns the 4-bit program counter, issues single-beat reads to a fixed-latency
// instruction memory, captures the returned word and presents its decoded
// fields under a valid/accept handshake.
module fetch_decode_unit #(
   parameter int unsigned INSTR_W = 19,
   parameter int unsigned MEM_LAT = 1,
   parameter logic [6:0]  HALT_OP = 7'h7F
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inc,
   input  logic               load,
   input  logic [3:0]         add_in,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               take_instr,
   output logic [3:0]         add_out,
   output logic               imem_en,
   output logic [3:0]         imem_addr,
   output logic [6:0]         op_code,
   output logic [3:0]         regdes,
   output logic [3:0]         regsrc1,
   output logic [3:0]         regsrc2,
   output logic               instr_valid,
   output logic               halted
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_VALID = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_HALT  = 3'd5;

   // Number of WAIT cycles; the memory latency is limited to 1..3.
   localparam logic [1:0] LAT_INIT = 2'(MEM_LAT);

   logic [2:0]         state_q, state_d;
   logic [3:0]         pc_q, pc_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               en_q, en_d;
   logic [3:0]         addr_q, addr_d;
   logic               valid_q, valid_d;
   logic               halted_q, halted_d;
   logic               pc_chg_s;
   logic               is_halt_s;

   // A PC change is any sampled inc/load, even if the PC value ends up equal.
   assign pc_chg_s  = inc | load;
   assign is_halt_s = (instr_q[18:12] == HALT_OP);

   // Next-state, program counter and capture logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;

      // load wins over inc; only load is honoured while halted.
      if (state_q == S_HALT) begin
         if (load) begin
            pc_d = add_in;
         end else begin
            pc_d = pc_q;
         end
      end else if (load) begin
         pc_d = add_in;
      end else if (inc) begin
         pc_d = pc_q + 4'd1;
      end else begin
         pc_d = pc_q;
      end

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            // A PC change here abandons this read and reissues at the new PC.
            if (pc_chg_s) begin
               state_d = S_REQ;
            end else begin
               state_d = S_WAIT;
               cnt_d   = LAT_INIT;
            end
         end
         S_WAIT: begin
            if (pc_chg_s) begin
               state_d = S_REQ;
               cnt_d   = 2'd0;
            end else if (cnt_q == 2'd1) begin
               state_d = S_VALID;
               instr_d = imem_rdata;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_VALID: begin
            // An accept is honoured even when it coincides with a PC change.
            if (take_instr) begin
               if (is_halt_s) begin
                  state_d = S_HALT;
               end else if (pc_chg_s) begin
                  state_d = S_REQ;
               end else begin
                  state_d = S_HOLD;
               end
            end else if (pc_chg_s) begin
               state_d = S_REQ;
            end else begin
               state_d = S_VALID;
            end
         end
         S_HOLD: begin
            if (pc_chg_s) begin
               state_d = S_REQ;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_HALT: begin
            if (load) begin
               state_d = S_REQ;
            end else begin
               state_d = S_HALT;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
         end
      endcase

      // Output registers are loaded from the next state so they line up with it.
      en_d     = (state_d == S_REQ);
      valid_d  = (state_d == S_VALID);
      halted_d = (state_d == S_HALT);
      if (state_d == S_REQ) begin
         addr_d = pc_d;
      end else begin
         addr_d = addr_q;
      end
   end

   // State and output registers with synchronous active-high reset on rst_n.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= 4'd0;
         cnt_q    <= 2'd0;
         instr_q  <= '0;
         en_q     <= 1'b0;
         addr_q   <= 4'd0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         instr_q  <= instr_d;
         en_q     <= en_d;
         addr_q   <= addr_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

   assign add_out     = pc_q;
   assign imem_en     = en_q;
   assign imem_addr   = addr_q;
   assign instr_valid = valid_q;
   assign halted      = halted_q;

   // Field split of the captured instruction word.
   assign op_code = instr_q[18:12];
   assign regdes  = instr_q[11:8];
   assign regsrc1 = instr_q[7:4];
   assign regsrc2 = instr_q[3:0];

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, each fed by its own fixed-latency memory model.
module tb_fetch_decode_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1, rst3, inc, load, take;
   logic [3:0] add_in;
   logic       sel;

   logic [18:0] rd1, rd3;
   logic [3:0]  ao1, ia1, rg1, s11, s21, ao3, ia3, rg3, s13, s23;
   logic [6:0]  op1, op3;
   logic        en1, v1, h1, en3, v3, h3;

   fetch_decode_unit #(.INSTR_W(19), .MEM_LAT(1), .HALT_OP(7'h7F)) dut1 (
      .clk(clk), .rst_n(rst1), .inc(inc), .load(load), .add_in(add_in),
      .imem_rdata(rd1), .take_instr(take), .add_out(ao1), .imem_en(en1),
      .imem_addr(ia1), .op_code(op1), .regdes(rg1), .regsrc1(s11),
      .regsrc2(s21), .instr_valid(v1), .halted(h1));

   fetch_decode_unit #(.INSTR_W(19), .MEM_LAT(3), .HALT_OP(7'h7F)) dut3 (
      .clk(clk), .rst_n(rst3), .inc(inc), .load(load), .add_in(add_in),
      .imem_rdata(rd3), .take_instr(take), .add_out(ao3), .imem_en(en3),
      .imem_addr(ia3), .op_code(op3), .regdes(rg3), .regsrc1(s13),
      .regsrc2(s23), .instr_valid(v3), .halted(h3));

   // Instance currently under test.
   logic [3:0] c_ao, c_ia, c_rd, c_s1, c_s2;
   logic [6:0] c_op;
   logic       c_en, c_v, c_h;
   assign c_ao = sel ? ao3 : ao1;
   assign c_ia = sel ? ia3 : ia1;
   assign c_op = sel ? op3 : op1;
   assign c_rd = sel ? rg3 : rg1;
   assign c_s1 = sel ? s13 : s11;
   assign c_s2 = sel ? s23 : s21;
   assign c_en = sel ? en3 : en1;
   assign c_v  = sel ? v3  : v1;
   assign c_h  = sel ? h3  : h1;

   // Instruction memory contents.
   function automatic logic [18:0] mem_word(input logic [3:0] a);
      case (a)
         4'd0:    mem_word = 19'h05312;
         4'd1:    mem_word = 19'h12A5C;
         4'd2:    mem_word = 19'h6ABCD;
         4'd4:    mem_word = 19'h01234;
         4'd5:    mem_word = 19'h7FFFF;
         4'd6:    mem_word = 19'h3F0F0;
         4'd9:    mem_word = 19'h40987;
         4'd15:   mem_word = 19'h7E111;
         default: mem_word = 19'h2A000 | {15'd0, a};
      endcase
   endfunction

   // Memory models: data valid MEM_LAT cycles after the strobe, junk otherwise.
   logic       p1_en = 1'b0;
   logic [3:0] p1_a  = 4'd0;
   logic [2:0] p3_en = 3'b000;
   logic [3:0] p3_a0 = 4'd0, p3_a1 = 4'd0, p3_a2 = 4'd0;
   always @(posedge clk) begin
      p1_en <= en1;
      p1_a  <= ia1;
      p3_en <= {p3_en[1:0], en3};
      p3_a0 <= ia3;
      p3_a1 <= p3_a0;
      p3_a2 <= p3_a1;
   end
   assign rd1 = p1_en    ? mem_word(p1_a)  : 19'h5A5A5;
   assign rd3 = p3_en[2] ? mem_word(p3_a2) : 19'h5A5A5;

   typedef struct packed {
      logic [6:0] op;
      logic [3:0] rd;
      logic [3:0] rs1;
      logic [3:0] rs2;
   } exp_t;

   typedef struct {
      bit         ld;
      bit         in;
      logic [3:0] ain;
      logic [3:0] pc;
      exp_t       f;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[6];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Wait for instr_valid, check latency from the REQ cycle, then score fields.
   task automatic expect_fetch(input string nm, input int lat);
      int   n;
      exp_t e;
      n = 0;
      while (c_v !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      chk({nm, "_lat"}, 32'(n), 32'(lat));
      if (sb.size() == 0) begin
         chk({nm, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({nm, "_op"},  32'(c_op), 32'(e.op));
         chk({nm, "_rd"},  32'(c_rd), 32'(e.rd));
         chk({nm, "_rs1"}, 32'(c_s1), 32'(e.rs1));
         chk({nm, "_rs2"}, 32'(c_s2), 32'(e.rs2));
      end
   endtask

   task automatic chk_req(input string nm, input logic [3:0] a);
      chk({nm, "_valid"}, 32'(c_v), 32'd0);
      chk({nm, "_pc"},    32'(c_ao), 32'(a));
      chk({nm, "_en"},    32'(c_en), 32'd1);
      chk({nm, "_addr"},  32'(c_ia), 32'(a));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{ld: 1'b1, in: 1'b0, ain: 4'd2,  pc: 4'd2,  f: '{7'h6A, 4'hB, 4'hC, 4'hD}};
      tbl[1] = '{ld: 1'b1, in: 1'b0, ain: 4'd15, pc: 4'd15, f: '{7'h7E, 4'h1, 4'h1, 4'h1}};
      tbl[2] = '{ld: 1'b0, in: 1'b1, ain: 4'd0,  pc: 4'd0,  f: '{7'h05, 4'h3, 4'h1, 4'h2}};
      tbl[3] = '{ld: 1'b0, in: 1'b1, ain: 4'd0,  pc: 4'd1,  f: '{7'h12, 4'hA, 4'h5, 4'hC}};
      tbl[4] = '{ld: 1'b1, in: 1'b1, ain: 4'd9,  pc: 4'd9,  f: '{7'h40, 4'h9, 4'h8, 4'h7}};
      tbl[5] = '{ld: 1'b1, in: 1'b0, ain: 4'd6,  pc: 4'd6,  f: '{7'h3F, 4'h0, 4'hF, 4'h0}};

      sel = 1'b0; rst1 = 1'b1; rst3 = 1'b1;
      inc = 1'b0; load = 1'b0; take = 1'b0; add_in = 4'd0;
      tick();
      tick();
      chk("rst_pc", 32'(c_ao), 32'd0);
      chk("rst_en", 32'(c_en), 32'd0);
      chk("rst_addr", 32'(c_ia), 32'd0);
      chk("rst_fields", 32'({c_op, c_rd, c_s1, c_s2}), 32'd0);
      chk("rst_valid", 32'(c_v), 32'd0);
      chk("rst_halted", 32'(c_h), 32'd0);

      // First fetch after reset release.
      rst1 = 1'b0;
      sb.push_back('{7'h05, 4'h3, 4'h1, 4'h2});
      tick();
      chk_req("first", 4'd0);
      expect_fetch("first", 2);

      // No accept for 10 cycles: everything held.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_stable", 32'({c_op, c_rd, c_s1, c_s2, c_v}), 32'({7'h05, 4'h3, 4'h1, 4'h2, 1'b1}));
      end
      take = 1'b1;
      tick();
      take = 1'b0;
      chk("accept_valid", 32'(c_v), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_no_en", 32'({c_en, c_v}), 32'd0);
      end
      inc = 1'b1;
      tick();
      inc = 1'b0;
      sb.push_back('{7'h12, 4'hA, 4'h5, 4'hC});
      chk_req("inc_req", 4'd1);
      expect_fetch("inc_fetch", 2);

      // Accept coinciding with a PC change goes straight to REQ.
      for (int i = 0; i < 6; i++) begin
         take = 1'b1; load = tbl[i].ld; inc = tbl[i].in; add_in = tbl[i].ain;
         tick();
         take = 1'b0; load = 1'b0; inc = 1'b0;
         sb.push_back(tbl[i].f);
         chk_req($sformatf("vec%0d", i), tbl[i].pc);
         expect_fetch($sformatf("vec%0d", i), 2);
      end

      // PC change in VALID without accept drops the instruction.
      inc = 1'b1;
      tick();
      inc = 1'b0;
      sb.push_back('{7'h2A, 4'h0, 4'h0, 4'h7});
      chk_req("valid_abort", 4'd7);
      expect_fetch("valid_abort", 2);

      // Halt opcode, ignored incs, load to resume.
      take = 1'b1; load = 1'b1; add_in = 4'd5;
      tick();
      take = 1'b0; load = 1'b0;
      sb.push_back('{7'h7F, 4'hF, 4'hF, 4'hF});
      chk_req("halt_req", 4'd5);
      expect_fetch("halt_fetch", 2);
      take = 1'b1;
      tick();
      take = 1'b0;
      chk("halt_set", 32'({c_h, c_v, c_en}), 32'({1'b1, 1'b0, 1'b0}));
      for (int i = 0; i < 3; i++) begin
         inc = 1'b1;
         tick();
         inc = 1'b0;
         chk("halt_inc", 32'({c_ao, c_en, c_h}), 32'({4'd5, 1'b0, 1'b1}));
         tick();
         chk("halt_idle_en", 32'(c_en), 32'd0);
      end
      load = 1'b1; add_in = 4'd4;
      tick();
      load = 1'b0;
      chk("halt_exit", 32'(c_h), 32'd0);
      sb.push_back('{7'h01, 4'h2, 4'h3, 4'h4});
      chk_req("halt_exit", 4'd4);
      expect_fetch("halt_exit", 2);

      // MEM_LAT=3 instance.
      rst1 = 1'b1; sel = 1'b1; rst3 = 1'b0;
      sb.push_back('{7'h05, 4'h3, 4'h1, 4'h2});
      tick();
      chk_req("l3_first", 4'd0);
      expect_fetch("l3_first", 4);

      // load on the second WAIT cycle: addr1 data must never appear.
      take = 1'b1; inc = 1'b1;
      tick();
      take = 1'b0; inc = 1'b0;
      chk_req("l3_req1", 4'd1);
      tick();
      tick();
      load = 1'b1; add_in = 4'd6;
      tick();
      load = 1'b0;
      sb.push_back('{7'h3F, 4'h0, 4'hF, 4'h0});
      chk_req("l3_abort", 4'd6);
      expect_fetch("l3_abort", 4);

      // Reset during WAIT: everything clears and fetch restarts at 0.
      take = 1'b1; inc = 1'b1;
      tick();
      take = 1'b0; inc = 1'b0;
      chk_req("l3_req7", 4'd7);
      tick();
      tick();
      rst3 = 1'b1;
      tick();
      rst3 = 1'b0;
      chk("l3_rst_all", 32'({c_ao, c_en, c_ia, c_op, c_rd, c_s1, c_s2, c_v, c_h}), 32'd0);
      tick();
      sb.push_back('{7'h05, 4'h3, 4'h1, 4'h2});
      chk_req("l3_restart", 4'd0);
      expect_fetch("l3_restart", 4);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Front-end stage directly upstream of the control unit.
- Owns the 4-bit program counter, driven by the control unit's inc/load/add_in, and returns add_out.
- Issues reads to a fixed-latency instruction memory and captures the returned word.
- Splits the word into op_code/regdes/regsrc1/regsrc2 and holds them stable under a valid/accept handshake until the control unit consumes them.

Parameters:
- INSTR_W, 19, instruction word width. Field map: [18:12] op_code, [11:8] regdes, [7:4] regsrc1, [3:0] regsrc2.
- MEM_LAT, 1, instruction memory read latency in cycles. Legal range 1..3.
- HALT_OP, 7'h7F, op_code value that halts fetching once accepted.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous reset, active-high: rst_n=1 resets the block on the next clk edge.
- inc, input, 1, pulse: PC <= PC+1.
- load, input, 1, pulse: PC <= add_in.
- add_in, input, 4, branch/jump target.
- imem_rdata, input, INSTR_W, instruction memory read data, valid MEM_LAT cycles after imem_en.
- take_instr, input, 1, control unit accepts the current instruction.
- add_out, output, 4, current PC.
- imem_en, output, 1, memory read strobe, one cycle wide.
- imem_addr, output, 4, memory read address.
- op_code, output, 7, decoded opcode field.
- regdes, output, 4, decoded destination register field.
- regsrc1, output, 4, decoded source register 1 field.
- regsrc2, output, 4, decoded source register 2 field.
- instr_valid, output, 1, decoded fields valid.
- halted, output, 1, HALT_OP accepted; fetching stopped.

Behaviour:
- Reset values: add_out=0, imem_en=0, imem_addr=0, op_code/regdes/regsrc1/regsrc2=0, instr_valid=0, halted=0, state=IDLE, latency counter=0. Reset takes effect in any state and discards any in-flight read.
- PC update:
  - load has priority over inc; load+inc in the same cycle gives PC=add_in.
  - inc at PC=15 wraps to 0.
  - The PC updates at the clk edge in which inc/load is sampled, in every state except HALT (see HALT).
- "PC change" means inc=1 or load=1 sampled in that cycle, even if the resulting PC value is unchanged.
- IDLE: always go to REQ next cycle.
- REQ: imem_en=1 and imem_addr=add_out for exactly one cycle. Go to WAIT with counter=MEM_LAT.
- WAIT:
  - Lasts MEM_LAT cycles.
  - On the final WAIT cycle, imem_rdata is registered into the field outputs, instr_valid goes to 1 from the next cycle, and the state goes to VALID.
- VALID:
  - Fields and instr_valid are held stable until take_instr=1.
  - On take_instr: instr_valid=0 next cycle. If op_code==HALT_OP, go to HALT with halted=1; otherwise go to HOLD.
- HOLD: wait for a PC change, then go to REQ next cycle using the updated PC.
- HALT:
  - Only load exits: PC<=add_in, halted=0, go to REQ.
  - inc is ignored while halted.
- Abort rules:
  - A PC change during REQ or WAIT drops the in-flight read (its data is never captured) and goes to REQ next cycle.
  - A PC change during VALID clears instr_valid next cycle and goes to REQ. If take_instr coincides with it, the accept is honoured: HALT_OP still enters HALT, otherwise go to REQ directly, skipping HOLD.
- Latency: reset release to first instr_valid is 2+MEM_LAT cycles (IDLE, REQ, MEM_LAT×WAIT). Fetch-to-fetch with immediate accept and inc is 3+MEM_LAT cycles.
- imem_en never asserts outside REQ. At most one read is outstanding.
- Fields are decoded combinationally from the internal instruction register. Outputs are 0 until the first capture.

Test Plan:
- Reset, MEM_LAT=1, imem word at addr0 = {7'h05,4'h3,4'h1,4'h2} → imem_en with addr=0 in cycle 1; instr_valid=1 from cycle 3; op_code=05, regdes=3, regsrc1=1, regsrc2=2.
- Hold take_instr=0 for 10 cycles, then pulse take_instr → fields stable throughout; instr_valid=0 the cycle after accept; HOLD until an inc pulse, then imem_addr=1.
- PC=15 plus inc → add_out=0 and next fetch addr=0. load=1 with inc=1 and add_in=9 → add_out=9.
- MEM_LAT=3: load add_in=6 on the second WAIT cycle → old data never appears; new REQ with addr=6; instr_valid carries addr6's word.
- Accept op_code=7F → halted=1, no imem_en; inc pulses leave add_out unchanged; load add_in=4 → halted=0, fetch addr=4.
- Assert rst_n mid-WAIT → next cycle all outputs zero, state IDLE; in-flight data ignored; fetch restarts at addr 0.
